calc_port_issuer: RTL and testbench
===================================

// Module: calc_port_issuer
// PURPOSE
//  Upstream driver stage for one calculator port: accepts operation requests (cmd, op1, op2) on a
//  valid/ready handshake and emits the two-cycle port protocol on cmd_in/data_in/tag_in.
//  Allocates one of 4 tags per command and holds the issued cmd per tag. Consumes resp_out/tag_out/
//  data_out, retires tags and returns tagged responses. Flags responses that never arrive (timeout)
//  and responses that carry a tag not outstanding (unexpected).
// PARAMETERS
//  TIMEOUT_CYCLES  64  cycles from accept to forced retire of an unanswered tag (1..2**CNT_W-1)
//  CNT_W           8   width of each per-tag age counter
// PORTS
//  clk             in   1     port clock; all logic on posedge
//  reset           in   1     asynchronous, active-high reset
//  req_valid       in   1     request present
//  req_ready       out  1     request can be accepted this cycle (combinational from state/tag pool)
//  req_cmd         in   [0:3] command code; 4'h0 is never issued (treated as accepted no-op, no tag)
//  req_op1/req_op2 in   [0:31] operands
//  cmd_in          out  [0:3] port command, 0 when idle
//  data_in         out  [0:31] op1 in CMD cycle, op2 in OP2 cycle, 0 otherwise
//  tag_in          out  [0:1] tag, valid in CMD cycle, 0 otherwise
//  resp_out        in   [0:1] port response: 00 none, 01 ok, 10 overflow/invalid, 11 internal error
//  tag_out         in   [0:1] tag of response
//  data_out        in   [0:31] result data
//  rsp_valid       out  1     one-cycle pulse: tagged response forwarded
//  rsp_tag/rsp_resp out [0:1] tag and resp code of forwarded response
//  rsp_cmd         out  [0:3] cmd originally issued with that tag
//  rsp_data        out  [0:31] data_out captured with response
//  timeout_valid   out  1     one-cycle pulse: tag retired by timeout
//  timeout_tag     out  [0:1] tag that timed out
//  err_unexpected  out  1     one-cycle pulse: resp_out!=0 with tag not outstanding
//  outstanding     out  [0:3] bit i set while tag i is in flight
// BEHAVIOUR
//  Reset: all outputs 0, FSM IDLE, outstanding=0, counters 0. Asserting reset mid-command aborts it.
//  Responses arriving after reset for pre-reset tags raise err_unexpected.
//  FSM IDLE/CMD/OP2, all port outputs registered:
//   IDLE: cmd_in=0,data_in=0,tag_in=0. Accept -> CMD.
//   CMD : cmd_in=req_cmd, data_in=op1, tag_in=tag. Always -> OP2.
//   OP2 : cmd_in=0, data_in=op2, tag_in=0. Accept -> CMD (back-to-back, 1 cmd/2 cycles), else -> IDLE.
//  req_ready = (state!=CMD) && (outstanding!=4'hF). Accept = req_valid && req_ready.
//  Tag alloc: lowest-index clear bit of outstanding; set at accept edge; cmd stored per tag.
//  Response path: resp_out/tag_out/data_out sampled at posedge; if resp_out!=0 and
//   outstanding[tag_out]: next cycle rsp_valid=1 with captured fields, bit cleared at same edge.
//   If bit clear: err_unexpected=1 next cycle, nothing forwarded, state unchanged.
//  A tag freed at edge N is allocatable for accepts at edge N+1 or later (not same edge).
//  Age counter per tag: cleared at accept, +1 per cycle while outstanding. Reaching TIMEOUT_CYCLES
//   clears bit, pulses timeout_valid/timeout_tag next cycle. Multiple same-cycle expiries reported
//   lowest tag first, one per cycle; others hold at limit until reported.
//  Response and timeout for same tag on same edge: response wins, no timeout pulse.
//  Response on tag currently in CMD cycle (same-edge issue) is unexpected (bit not yet visible).
//  Counters saturate; no wrap.
// TESTING
//  Single op: req cmd=1,op1=5,op2=3 -> CMD cycle cmd_in=1,data_in=5,tag_in=0; OP2 data_in=3; resp 01 tag0 data 8 -> rsp_valid,rsp_cmd=1,rsp_data=8.
//  Back-to-back 5 reqs with no responses -> tags 0,1,2,3 issued 2 cycles apart, req_ready low after 4th, outstanding=4'hF.
//  Out-of-order retire: respond tag2 then tag0 -> outstanding 4'hB then 4'hA; next req gets tag 0.
//  No response for tag1 -> timeout_valid,timeout_tag=1 exactly TIMEOUT_CYCLES+1 cycles after accept edge, bit cleared.
//  resp_out=01 tag_out=3 with tag3 free -> err_unexpected pulse, no rsp_valid, outstanding unchanged.
//  reset asserted in OP2 cycle -> outputs 0 immediately; later resp for old tag -> err_unexpected.

Source files
------------

// File: rtl/calc_port_issuer.sv
// calc_port_issuer: drives the two-cycle calculator port protocol, tracks 4 tags and retires them by response or timeout.
module calc_port_issuer #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_cmd,
  input  logic [31:0] req_op1,
  input  logic [31:0] req_op2,
  output logic [3:0]  cmd_in,
  output logic [31:0] data_in,
  output logic [1:0]  tag_in,
  input  logic [1:0]  resp_out,
  input  logic [1:0]  tag_out,
  input  logic [31:0] data_out,
  output logic        rsp_valid,
  output logic [1:0]  rsp_tag,
  output logic [1:0]  rsp_resp,
  output logic [3:0]  rsp_cmd,
  output logic [31:0] rsp_data,
  output logic        timeout_valid,
  output logic [1:0]  timeout_tag,
  output logic        err_unexpected,
  output logic [3:0]  outstanding
);
  typedef enum logic [1:0] {IDLE, CMD, OP2} state_t;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES);
  state_t state_q, state_d;
  logic [3:0] cmd_q, cmd_d, out_q, out_d, rsp_cmd_q, rsp_cmd_d, expired;
  logic [31:0] data_q, data_d, op2_q, rsp_data_q, rsp_data_d;
  logic [1:0] tag_q, tag_d, rsp_tag_q, rsp_tag_d, rsp_resp_q, rsp_resp_d, to_tag_q, free_tag, to_tag;
  logic rsp_valid_q, to_valid_q, err_q, accept, issue, resp_hit;
  logic [CNT_W-1:0] age_q [4];
  logic [CNT_W-1:0] age_d [4];
  logic [3:0] tag_cmd_q [4];
  assign req_ready = (state_q != CMD) && (out_q != 4'hF);
  assign accept = req_valid && req_ready;
  // a zero command completes the handshake but never occupies the port or a tag
  assign issue = accept && |req_cmd;
  assign free_tag = !out_q[0] ? 2'd0 : !out_q[1] ? 2'd1 : !out_q[2] ? 2'd2 : 2'd3;
  assign resp_hit = |resp_out && out_q[tag_out];
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      expired[i] = out_q[i] && age_q[i] >= LIMIT && !(resp_hit && tag_out == 2'(i));
      age_d[i] = (issue && free_tag == 2'(i)) ? '0 : (out_q[i] && age_q[i] < LIMIT) ? age_q[i] + 1'b1 : age_q[i];
    end
  end
  assign to_tag = expired[0] ? 2'd0 : expired[1] ? 2'd1 : expired[2] ? 2'd2 : expired[3] ? 2'd3 : 2'd0;
  assign out_d = (out_q & ~(resp_hit ? 4'b1 << tag_out : 4'b0) & ~(|expired ? 4'b1 << to_tag : 4'b0))
               | (issue ? 4'b1 << free_tag : 4'b0);
  assign rsp_tag_d = resp_hit ? tag_out : 2'd0;
  assign rsp_resp_d = resp_hit ? resp_out : 2'd0;
  assign rsp_cmd_d = resp_hit ? tag_cmd_q[tag_out] : 4'd0;
  assign rsp_data_d = resp_hit ? data_out : 32'd0;
  always_comb begin
    state_d = IDLE;
    cmd_d = 4'd0;
    data_d = 32'd0;
    tag_d = 2'd0;
    if (state_q == CMD) begin
      state_d = OP2;
      data_d = op2_q;
    end else if (issue) begin
      state_d = CMD;
      cmd_d = req_cmd;
      data_d = req_op1;
      tag_d = free_tag;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cmd_q <= '0;
      data_q <= '0;
      tag_q <= '0;
      op2_q <= '0;
      out_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_tag_q <= '0;
      rsp_resp_q <= '0;
      rsp_cmd_q <= '0;
      rsp_data_q <= '0;
      to_valid_q <= 1'b0;
      to_tag_q <= '0;
      err_q <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        age_q[i] <= '0;
        tag_cmd_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      cmd_q <= cmd_d;
      data_q <= data_d;
      tag_q <= tag_d;
      if (issue) op2_q <= req_op2;
      if (issue) tag_cmd_q[free_tag] <= req_cmd;
      out_q <= out_d;
      rsp_valid_q <= resp_hit;
      rsp_tag_q <= rsp_tag_d;
      rsp_resp_q <= rsp_resp_d;
      rsp_cmd_q <= rsp_cmd_d;
      rsp_data_q <= rsp_data_d;
      to_valid_q <= |expired;
      to_tag_q <= to_tag;
      err_q <= |resp_out && !out_q[tag_out];
      for (int i = 0; i < 4; i++) age_q[i] <= age_d[i];
    end
  end
  assign cmd_in = cmd_q;
  assign data_in = data_q;
  assign tag_in = tag_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_tag = rsp_tag_q;
  assign rsp_resp = rsp_resp_q;
  assign rsp_cmd = rsp_cmd_q;
  assign rsp_data = rsp_data_q;
  assign timeout_valid = to_valid_q;
  assign timeout_tag = to_tag_q;
  assign err_unexpected = err_q;
  assign outstanding = out_q;
endmodule

// File: tb/tb_calc_port_issuer.sv
// tb_calc_port_issuer: directed vector table plus timeout/reset corner sequences for calc_port_issuer.
module tb_calc_port_issuer;
  logic clk = 1'b0, reset = 1'b0, req_valid = 1'b0, req_ready;
  logic [3:0] req_cmd = '0, cmd_in, rsp_cmd, outstanding;
  logic [31:0] req_op1 = '0, req_op2 = '0, data_in, data_out = '0, rsp_data;
  logic [1:0] tag_in, resp_out = '0, tag_out = '0, rsp_tag, rsp_resp, timeout_tag;
  logic rsp_valid, timeout_valid, err_unexpected;
  int checks = 0, errors = 0;
  calc_port_issuer dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready), .req_cmd(req_cmd),
    .req_op1(req_op1), .req_op2(req_op2), .cmd_in(cmd_in), .data_in(data_in), .tag_in(tag_in),
    .resp_out(resp_out), .tag_out(tag_out), .data_out(data_out), .rsp_valid(rsp_valid),
    .rsp_tag(rsp_tag), .rsp_resp(rsp_resp), .rsp_cmd(rsp_cmd), .rsp_data(rsp_data),
    .timeout_valid(timeout_valid), .timeout_tag(timeout_tag), .err_unexpected(err_unexpected),
    .outstanding(outstanding)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic v; logic [3:0] cmd; logic [31:0] op1, op2; logic [1:0] resp, rtag; logic [31:0] rdata;
    logic rdy; logic [3:0] ci; logic [31:0] di; logic [1:0] ti;
    logic rv; logic [1:0] rt, rr; logic [3:0] rc; logic [31:0] rd; logic err; logic [3:0] out;
  } vec_t;
  vec_t tbl [20];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic drive(input logic v, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                       input logic [1:0] r, input logic [1:0] t, input logic [31:0] d);
    req_valid = v; req_cmd = c; req_op1 = a; req_op2 = b; resp_out = r; tag_out = t; data_out = d;
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset;
    drive(0, 0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask
  initial begin
    int k;
    tbl[0]  = '{1,1,5,3,0,0,0,         0,1,5,0,   0,0,0,0,0,      0,4'h1};
    tbl[1]  = '{1,2,7,9,0,0,0,         1,0,3,0,   0,0,0,0,0,      0,4'h1};
    tbl[2]  = '{0,0,0,0,1,0,8,         1,0,0,0,   1,0,1,1,8,      0,4'h0};
    tbl[3]  = '{1,3,10,11,0,0,0,       0,3,10,0,  0,0,0,0,0,      0,4'h1};
    tbl[4]  = '{1,4,20,21,0,0,0,       1,0,11,0,  0,0,0,0,0,      0,4'h1};
    tbl[5]  = '{1,4,20,21,0,0,0,       0,4,20,1,  0,0,0,0,0,      0,4'h3};
    tbl[6]  = '{1,5,30,31,0,0,0,       1,0,21,0,  0,0,0,0,0,      0,4'h3};
    tbl[7]  = '{1,5,30,31,0,0,0,       0,5,30,2,  0,0,0,0,0,      0,4'h7};
    tbl[8]  = '{1,6,40,41,0,0,0,       1,0,31,0,  0,0,0,0,0,      0,4'h7};
    tbl[9]  = '{1,6,40,41,0,0,0,       0,6,40,3,  0,0,0,0,0,      0,4'hF};
    tbl[10] = '{1,7,50,51,0,0,0,       0,0,41,0,  0,0,0,0,0,      0,4'hF};
    tbl[11] = '{1,7,50,51,0,0,0,       0,0,0,0,   0,0,0,0,0,      0,4'hF};
    tbl[12] = '{0,0,0,0,1,2,32'h22,    1,0,0,0,   1,2,1,5,32'h22, 0,4'hB};
    tbl[13] = '{0,0,0,0,2,0,32'h44,    1,0,0,0,   1,0,2,3,32'h44, 0,4'hA};
    tbl[14] = '{0,0,0,0,1,2,32'h55,    1,0,0,0,   0,0,0,0,0,      1,4'hA};
    tbl[15] = '{1,8,60,61,0,0,0,       0,8,60,0,  0,0,0,0,0,      0,4'hB};
    tbl[16] = '{0,0,0,0,1,3,32'h33,    1,0,61,0,  1,3,1,6,32'h33, 0,4'h3};
    tbl[17] = '{0,0,0,0,0,0,0,         1,0,0,0,   0,0,0,0,0,      0,4'h3};
    tbl[18] = '{1,9,70,71,1,2,32'h77,  0,9,70,2,  0,0,0,0,0,      1,4'h7};
    tbl[19] = '{0,0,0,0,0,0,0,         1,0,71,0,  0,0,0,0,0,      0,4'h7};
    do_reset();
    chk("reset cmd_in", 32'(cmd_in), 0);
    chk("reset data_in", data_in, 0);
    chk("reset outstanding", 32'(outstanding), 0);
    chk("reset ready", 32'(req_ready), 1);
    chk("reset pulses", {29'd0, rsp_valid, timeout_valid, err_unexpected}, 0);
    for (int i = 0; i < 20; i++) begin
      drive(tbl[i].v, tbl[i].cmd, tbl[i].op1, tbl[i].op2, tbl[i].resp, tbl[i].rtag, tbl[i].rdata);
      tick();
      chk($sformatf("v%0d ready", i), 32'(req_ready), 32'(tbl[i].rdy));
      chk($sformatf("v%0d port", i), {26'd0, cmd_in, tag_in}, {26'd0, tbl[i].ci, tbl[i].ti});
      chk($sformatf("v%0d data_in", i), data_in, tbl[i].di);
      chk($sformatf("v%0d rsp", i), {22'd0, rsp_valid, rsp_tag, rsp_resp, rsp_cmd},
          {22'd0, tbl[i].rv, tbl[i].rt, tbl[i].rr, tbl[i].rc});
      chk($sformatf("v%0d rsp_data", i), rsp_data, tbl[i].rd);
      chk($sformatf("v%0d err", i), 32'(err_unexpected), 32'(tbl[i].err));
      chk($sformatf("v%0d timeout", i), 32'(timeout_valid), 0);
      chk($sformatf("v%0d outstanding", i), 32'(outstanding), 32'(tbl[i].out));
    end
    // tag1 left unanswered: expect the pulse 65 edges after its accept edge
    do_reset();
    drive(1, 1, 1, 2, 0, 0, 0); tick();
    drive(0, 0, 0, 0, 0, 0, 0); tick();
    drive(1, 2, 3, 4, 0, 0, 0); tick();
    drive(0, 0, 0, 0, 1, 0, 32'h9); tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("to tag0 answered", 32'(rsp_valid), 1);
    k = 0;
    for (int j = 2; j <= 100 && k == 0; j++) begin
      tick();
      if (timeout_valid) k = j;
    end
    chk("to latency", k, 65);
    chk("to tag", 32'(timeout_tag), 1);
    chk("to outstanding", 32'(outstanding), 0);
    tick();
    chk("to one pulse", 32'(timeout_valid), 0);
    // response landing on the expiry edge takes precedence
    do_reset();
    drive(1, 7, 1, 2, 0, 0, 0); tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    repeat (64) tick();
    chk("race pre", 32'(outstanding), 1);
    drive(0, 0, 0, 0, 3, 0, 32'hAB); tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("race rsp", {27'd0, rsp_valid, rsp_cmd}, {27'd0, 1'b1, 4'd7});
    chk("race no timeout", 32'(timeout_valid), 0);
    chk("race outstanding", 32'(outstanding), 0);
    tick();
    chk("race no late timeout", 32'(timeout_valid), 0);
    // reset during OP2, then answer the forgotten tag
    do_reset();
    drive(1, 1, 5, 3, 0, 0, 0); tick();
    drive(0, 0, 0, 0, 0, 0, 0); tick();
    chk("mid op2 data", data_in, 3);
    #2 reset = 1'b1;
    #1;
    chk("mid reset outputs", {cmd_in, data_in[27:0]}, 0);
    chk("mid reset outstanding", 32'(outstanding), 0);
    #1 reset = 1'b0;
    drive(0, 0, 0, 0, 1, 0, 32'h8); tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("stale err", 32'(err_unexpected), 1);
    chk("stale no rsp", 32'(rsp_valid), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
